// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_reg
// Brief   : ID/EX pipeline register with load-use bubble insertion, flush and
//           condition squash, and a saturating bubble counter.
// Revision: 1.0
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_shift_imm,
    input  logic              ID_Load_Inst,
    input  logic              S,
    input  logic              ID_RF_enable,
    input  logic              B_L,
    input  logic              m_enable,
    input  logic              m_rw,
    input  logic [3:0]        ID_ALU_Op,
    input  logic [1:0]        m_size,
    input  logic              ID_cond_pass,
    input  logic [DATA_W-1:0] ID_Rn_val,
    input  logic [DATA_W-1:0] ID_Rm_val,
    input  logic [DATA_W-1:0] ID_Rd_val,
    input  logic [11:0]       ID_imm,
    input  logic [REG_W-1:0]  ID_Rn,
    input  logic [REG_W-1:0]  ID_Rm,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_uses_Rn,
    input  logic              ID_uses_Rm,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              EX_shift_imm,
    output logic              EX_Load_Inst,
    output logic              EX_S,
    output logic              EX_RF_enable,
    output logic              EX_B_L,
    output logic              EX_m_enable,
    output logic              EX_m_rw,
    output logic [3:0]        EX_ALU_Op,
    output logic [1:0]        EX_m_size,
    output logic              EX_cond_pass,
    output logic [DATA_W-1:0] EX_Rn_val,
    output logic [DATA_W-1:0] EX_Rm_val,
    output logic [DATA_W-1:0] EX_Rd_val,
    output logic [11:0]       EX_imm,
    output logic [REG_W-1:0]  EX_Rn,
    output logic [REG_W-1:0]  EX_Rm,
    output logic [REG_W-1:0]  EX_Rd,
    output logic              EX_valid,
    output logic              IF_ID_hold,
    output logic              load_use_hz,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int CTRL_W = 14;
    localparam int WORD_W = CTRL_W + 3 * DATA_W + 12 + 3 * REG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WORD_W-1:0] id_word;
    logic [WORD_W-1:0] ex_word;
    logic              bubble;
    logic              count_bubble;

    // Whole stage moves as one word so a bubble zeroes control, data and indices together.
    assign id_word = {ID_shift_imm, ID_Load_Inst, S, ID_RF_enable, B_L, m_enable, m_rw,
                      ID_ALU_Op, m_size, ID_cond_pass, ID_Rn_val, ID_Rm_val, ID_Rd_val,
                      ID_imm, ID_Rn, ID_Rm, ID_Rd};

    assign {EX_shift_imm, EX_Load_Inst, EX_S, EX_RF_enable, EX_B_L, EX_m_enable, EX_m_rw,
            EX_ALU_Op, EX_m_size, EX_cond_pass, EX_Rn_val, EX_Rm_val, EX_Rd_val,
            EX_imm, EX_Rn, EX_Rm, EX_Rd} = ex_word;

    assign load_use_hz = EX_valid & EX_Load_Inst & EX_RF_enable &
                         ((ID_uses_Rn & (ID_Rn == EX_Rd)) | (ID_uses_Rm & (ID_Rm == EX_Rd)));

    assign IF_ID_hold   = mem_stall | (load_use_hz & ~flush);
    assign count_bubble = flush | load_use_hz;
    assign bubble       = count_bubble | ~ID_cond_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_word      <= '0;
            EX_valid     <= 1'b0;
            bubble_count <= '0;
        end else if (!mem_stall) begin
            if (bubble) begin
                ex_word  <= '0;
                EX_valid <= 1'b0;
            end else begin
                ex_word  <= id_word;
                EX_valid <= 1'b1;
            end
            // Condition-failed squashes are architectural NOPs, not counted as bubbles.
            if (count_bubble && (bubble_count != CNT_MAX))
                bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// Testbench for id_ex_stage_reg: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the stage rules.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        shift_imm, load, s, rf_en, bl, m_en, m_rw;
        logic [3:0]  alu;
        logic [1:0]  size;
        logic        cond;
        logic [31:0] rn_val, rm_val, rd_val;
        logic [11:0] imm;
        logic [3:0]  rn, rm, rd;
    } ex_t;

    logic clk, rst_n, uses_rn, uses_rm, flush, mem_stall;
    ex_t  id;

    logic        EX_shift_imm, EX_Load_Inst, EX_S, EX_RF_enable, EX_B_L, EX_m_enable, EX_m_rw;
    logic [3:0]  EX_ALU_Op, EX_Rn, EX_Rm, EX_Rd;
    logic [1:0]  EX_m_size;
    logic        EX_cond_pass, EX_valid, IF_ID_hold, load_use_hz;
    logic [31:0] EX_Rn_val, EX_Rm_val, EX_Rd_val;
    logic [11:0] EX_imm;
    logic [15:0] bubble_count;
    ex_t         act;

    logic        d2_si, d2_ld, d2_s, d2_rf, d2_bl, d2_me, d2_rw, d2_cp, d2_valid, d2_hold, d2_hz;
    logic [3:0]  d2_alu, d2_rn, d2_rm, d2_rd;
    logic [1:0]  d2_sz, d2_cnt;
    logic [31:0] d2_rnv, d2_rmv, d2_rdv;
    logic [11:0] d2_imm;

    // Reference model state
    ex_t m_ex;
    logic m_valid;
    int m_cnt, m_cnt2;
    int errors = 0, checks = 0;

    assign act = {EX_shift_imm, EX_Load_Inst, EX_S, EX_RF_enable, EX_B_L, EX_m_enable, EX_m_rw,
                  EX_ALU_Op, EX_m_size, EX_cond_pass, EX_Rn_val, EX_Rm_val, EX_Rd_val,
                  EX_imm, EX_Rn, EX_Rm, EX_Rd};

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n),
        .ID_shift_imm(id.shift_imm), .ID_Load_Inst(id.load), .S(id.s), .ID_RF_enable(id.rf_en),
        .B_L(id.bl), .m_enable(id.m_en), .m_rw(id.m_rw), .ID_ALU_Op(id.alu), .m_size(id.size),
        .ID_cond_pass(id.cond), .ID_Rn_val(id.rn_val), .ID_Rm_val(id.rm_val),
        .ID_Rd_val(id.rd_val), .ID_imm(id.imm), .ID_Rn(id.rn), .ID_Rm(id.rm), .ID_Rd(id.rd),
        .ID_uses_Rn(uses_rn), .ID_uses_Rm(uses_rm), .flush(flush), .mem_stall(mem_stall),
        .EX_shift_imm(EX_shift_imm), .EX_Load_Inst(EX_Load_Inst), .EX_S(EX_S),
        .EX_RF_enable(EX_RF_enable), .EX_B_L(EX_B_L), .EX_m_enable(EX_m_enable),
        .EX_m_rw(EX_m_rw), .EX_ALU_Op(EX_ALU_Op), .EX_m_size(EX_m_size),
        .EX_cond_pass(EX_cond_pass), .EX_Rn_val(EX_Rn_val), .EX_Rm_val(EX_Rm_val),
        .EX_Rd_val(EX_Rd_val), .EX_imm(EX_imm), .EX_Rn(EX_Rn), .EX_Rm(EX_Rm), .EX_Rd(EX_Rd),
        .EX_valid(EX_valid), .IF_ID_hold(IF_ID_hold), .load_use_hz(load_use_hz),
        .bubble_count(bubble_count)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .ID_shift_imm(id.shift_imm), .ID_Load_Inst(id.load), .S(id.s), .ID_RF_enable(id.rf_en),
        .B_L(id.bl), .m_enable(id.m_en), .m_rw(id.m_rw), .ID_ALU_Op(id.alu), .m_size(id.size),
        .ID_cond_pass(id.cond), .ID_Rn_val(id.rn_val), .ID_Rm_val(id.rm_val),
        .ID_Rd_val(id.rd_val), .ID_imm(id.imm), .ID_Rn(id.rn), .ID_Rm(id.rm), .ID_Rd(id.rd),
        .ID_uses_Rn(uses_rn), .ID_uses_Rm(uses_rm), .flush(flush), .mem_stall(mem_stall),
        .EX_shift_imm(d2_si), .EX_Load_Inst(d2_ld), .EX_S(d2_s), .EX_RF_enable(d2_rf),
        .EX_B_L(d2_bl), .EX_m_enable(d2_me), .EX_m_rw(d2_rw), .EX_ALU_Op(d2_alu),
        .EX_m_size(d2_sz), .EX_cond_pass(d2_cp), .EX_Rn_val(d2_rnv), .EX_Rm_val(d2_rmv),
        .EX_Rd_val(d2_rdv), .EX_imm(d2_imm), .EX_Rn(d2_rn), .EX_Rm(d2_rm), .EX_Rd(d2_rd),
        .EX_valid(d2_valid), .IF_ID_hold(d2_hold), .load_use_hz(d2_hz), .bubble_count(d2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_hz();
        return m_valid && m_ex.load && m_ex.rf_en &&
               ((uses_rn && id.rn == m_ex.rd) || (uses_rm && id.rm == m_ex.rd));
    endfunction

    // Advance the model by one edge using the pre-edge inputs, then step past the edge.
    task automatic tick();
        logic hz;
        hz = m_hz();
        if (!mem_stall) begin
            if (flush || hz) begin
                m_ex = '0; m_valid = 1'b0;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end else if (!id.cond) begin
                m_ex = '0; m_valid = 1'b0;
            end else begin
                m_ex = id; m_valid = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        id = '0; id.cond = 1'b1; uses_rn = 1'b0; uses_rm = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ex = '0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic random_id();
        id.shift_imm = 1'($urandom); id.s = 1'($urandom); id.bl = 1'($urandom);
        id.load = 1'($urandom); id.rf_en = ($urandom_range(0, 3) != 0);
        id.m_en = 1'($urandom); id.m_rw = 1'($urandom);
        id.alu = 4'($urandom); id.size = 2'($urandom); id.cond = ($urandom_range(0, 99) < 85);
        id.rn_val = $urandom; id.rm_val = $urandom; id.rd_val = $urandom; id.imm = 12'($urandom);
        id.rn = 4'($urandom_range(0, 3)); id.rm = 4'($urandom_range(0, 3));
        id.rd = 4'($urandom_range(0, 3));
        uses_rn = 1'($urandom); uses_rm = 1'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act !== '0 || EX_valid !== 1'b0 || bubble_count !== 16'd0) begin
            errors++; $display("FAIL reset_state: act=%h valid=%b cnt=%0d, want 0", act, EX_valid, bubble_count);
        end
        random_id(); id.cond = 1'b1; tick();
        flush = 1'b1; tick(); flush = 1'b0;
        random_id(); id.cond = 1'b1; tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act !== '0 || EX_valid !== 1'b0 || bubble_count !== 16'd0 || d2_cnt !== 2'd0) begin
            errors++; $display("FAIL async_reset: act=%h valid=%b cnt=%0d, want 0", act, EX_valid, bubble_count);
        end
        do_reset();
    endtask

    task automatic test_passthrough();
        ex_t e;
        do_reset();
        id.alu = 4'b0100; id.s = 1'b1; id.rn_val = 32'h5; id.rd = 4'd3; id.cond = 1'b1;
        e = id;
        tick();
        checks++;
        if (act !== e || EX_valid !== 1'b1 || EX_ALU_Op !== 4'd4 || EX_Rd !== 4'd3 || EX_Rn_val !== 32'h5) begin
            errors++; $display("FAIL passthrough: act=%h valid=%b, want %h valid=1", act, EX_valid, e);
        end
        id = '0; id.cond = 1'b1;
        tick();
        checks++;
        if (EX_valid !== 1'b1 || EX_cond_pass !== 1'b1 || EX_ALU_Op !== 4'd0 || EX_Rn_val !== 32'd0) begin
            errors++; $display("FAIL zero_nop: valid=%b alu=%h rn_val=%h, want valid=1 zeros", EX_valid, EX_ALU_Op, EX_Rn_val);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id.load = 1'b1; id.rf_en = 1'b1; id.rd = 4'd2;
        tick();
        id = '0; id.cond = 1'b1; id.alu = 4'd9; id.rm = 4'd2; id.rn = 4'd5; uses_rm = 1'b1;
        #2;
        checks++;
        if (load_use_hz !== 1'b1 || IF_ID_hold !== 1'b1) begin
            errors++; $display("FAIL load_use_detect: hz=%b hold=%b, want 1 1", load_use_hz, IF_ID_hold);
        end
        tick();
        checks++;
        if (EX_valid !== 1'b0 || act !== '0 || bubble_count !== 16'd1) begin
            errors++; $display("FAIL load_use_bubble: valid=%b cnt=%0d, want 0 1", EX_valid, bubble_count);
        end
        #2;
        checks++;
        if (load_use_hz !== 1'b0 || IF_ID_hold !== 1'b0) begin
            errors++; $display("FAIL load_use_release: hz=%b hold=%b, want 0 0", load_use_hz, IF_ID_hold);
        end
        tick();
        checks++;
        if (EX_valid !== 1'b1 || EX_Rm !== 4'd2 || EX_ALU_Op !== 4'd9 || bubble_count !== 16'd1) begin
            errors++; $display("FAIL load_use_capture: valid=%b rm=%0d alu=%0d cnt=%0d, want 1 2 9 1", EX_valid, EX_Rm, EX_ALU_Op, bubble_count);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        id.load = 1'b1; id.rf_en = 1'b1; id.rd = 4'd7;
        tick();
        id = '0; id.cond = 1'b1; id.rn = 4'd7; uses_rn = 1'b1; flush = 1'b1;
        #2;
        checks++;
        if (load_use_hz !== 1'b1 || IF_ID_hold !== 1'b0) begin
            errors++; $display("FAIL flush_hazard_hold: hz=%b hold=%b, want 1 0", load_use_hz, IF_ID_hold);
        end
        tick();
        checks++;
        if (EX_valid !== 1'b0 || act !== '0 || bubble_count !== 16'd1) begin
            errors++; $display("FAIL flush_hazard_bubble: valid=%b cnt=%0d, want 0 1", EX_valid, bubble_count);
        end
    endtask

    task automatic test_mem_stall();
        ex_t e;
        do_reset();
        random_id(); id.cond = 1'b1; e = id;
        tick();
        for (int i = 0; i < 3; i++) begin
            random_id(); flush = 1'b1; mem_stall = 1'b1;
            #2;
            checks++;
            if (IF_ID_hold !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: hold=%b, want 1", i, IF_ID_hold);
            end
            tick();
            checks++;
            if (act !== e || EX_valid !== 1'b1 || bubble_count !== 16'd0) begin
                errors++; $display("FAIL stall_freeze[%0d]: act=%h valid=%b cnt=%0d, want %h 1 0", i, act, EX_valid, bubble_count, e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_cond_and_saturation();
        do_reset();
        random_id(); id.cond = 1'b0; uses_rn = 1'b0; uses_rm = 1'b0;
        tick();
        checks++;
        if (EX_valid !== 1'b0 || act !== '0 || bubble_count !== 16'd0) begin
            errors++; $display("FAIL cond_fail: valid=%b cnt=%0d act=%h, want 0 0 0", EX_valid, bubble_count, act);
        end
        idle_inputs(); flush = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b0;
        checks++;
        if (d2_cnt !== 2'd3 || bubble_count !== 16'd5) begin
            errors++; $display("FAIL saturate: cnt2=%0d cnt=%0d, want 3 5", d2_cnt, bubble_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            random_id();
            flush = ($urandom_range(0, 9) == 0);
            mem_stall = ($urandom_range(0, 6) == 0);
            #2;
            checks++;
            if (load_use_hz !== m_hz() || IF_ID_hold !== (mem_stall || (m_hz() && !flush))) begin
                errors++; $display("FAIL rand_comb[%0d]: hz=%b hold=%b, want %b %b", i, load_use_hz, IF_ID_hold, m_hz(), mem_stall || (m_hz() && !flush));
            end
            tick();
            checks++;
            if (act !== m_ex || EX_valid !== m_valid || bubble_count !== 16'(m_cnt) || d2_cnt !== 2'(m_cnt2)) begin
                errors++; $display("FAIL rand_state[%0d]: act=%h v=%b c=%0d c2=%0d, want %h %b %0d %0d", i, act, EX_valid, bubble_count, d2_cnt, m_ex, m_valid, m_cnt, m_cnt2);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        m_ex = '0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
        #1;
        test_reset();
        test_passthrough();
        test_load_use();
        test_flush_hazard();
        test_mem_stall();
        test_cond_and_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
